// File: rtl/nios2_debug_pkg.sv
// nios2_debug_pkg: shared action indices, scheduler FSM states and default payload width
package nios2_debug_pkg;
  localparam int DEF_JDO_W = 38;
  localparam logic [2:0] ACT_OCIMEM_A  = 3'd0;
  localparam logic [2:0] ACT_OCIMEM_B  = 3'd1;
  localparam logic [2:0] ACT_BREAK_A   = 3'd2;
  localparam logic [2:0] ACT_BREAK_B   = 3'd3;
  localparam logic [2:0] ACT_BREAK_C   = 3'd4;
  localparam logic [2:0] ACT_TRACECTRL = 3'd5;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} sched_state_e;
endpackage

// File: rtl/nios2_debug_action_fifo.sv
// nios2_debug_action_fifo: synchronous FIFO with occupancy output, push accepted when not full or popping
module nios2_debug_action_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 41,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_level
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_wr_en;
  assign o_level = r_wr - r_rd;
  assign w_wr_en = i_push && (o_level != (AW+1)'(DEPTH) || i_pop);
  assign o_dout = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk)
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (AW+1)'(w_wr_en);
      r_rd <= r_rd + (AW+1)'(i_pop);
    end
endmodule

// File: rtl/nios2_debug_action_sched.sv
// nios2_debug_action_sched: queues debug action pulses and issues them one at a time with timeout and sticky errors
module nios2_debug_action_sched
  import nios2_debug_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int JDO_W = DEF_JDO_W,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       act_pulse,
  input  logic [JDO_W-1:0] act_jdo,
  output logic             cmd_valid,
  output logic [2:0]       cmd_type,
  output logic [JDO_W-1:0] cmd_data,
  input  logic             cmd_ready,
  output logic             busy,
  output logic [LW-1:0]    level,
  output logic             overflow_err,
  output logic             multi_err,
  output logic             timeout_err,
  input  logic             clr_err
);
  sched_state_e r_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic [2:0] r_type, w_idx;
  logic [JDO_W-1:0] r_data;
  logic [JDO_W+2:0] w_head;
  logic r_ovf, r_multi, r_tmo;
  logic w_push, w_pop, w_multi, w_ovf, w_done, w_abort;
  assign w_push = |act_pulse;
  assign w_multi = (act_pulse & (act_pulse - 6'd1)) != 6'd0;
  assign w_idx = act_pulse[0] ? ACT_OCIMEM_A :
                 act_pulse[1] ? ACT_OCIMEM_B :
                 act_pulse[2] ? ACT_BREAK_A :
                 act_pulse[3] ? ACT_BREAK_B :
                 act_pulse[4] ? ACT_BREAK_C : ACT_TRACECTRL;
  assign w_pop = r_state == IDLE && level != '0;
  assign w_ovf = w_push && level == LW'(FIFO_DEPTH) && !w_pop;
  assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
  assign w_done = r_state == ISSUE && cmd_ready;
  assign w_abort = r_state == ISSUE && !cmd_ready && w_cnt_inc >= CNT_W'(TIMEOUT);
  assign cmd_valid = r_state == ISSUE;
  assign cmd_type = r_type;
  assign cmd_data = r_data;
  assign busy = level != '0 || r_state != IDLE;
  assign overflow_err = r_ovf;
  assign multi_err = r_multi;
  assign timeout_err = r_tmo;
  nios2_debug_action_fifo #(.DEPTH(FIFO_DEPTH), .W(JDO_W + 3)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({w_idx, act_jdo}),
    .o_dout  (w_head),
    .o_level (level)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_type  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_multi <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_pop ? ISSUE : (w_done || w_abort) ? GAP : r_state == GAP ? IDLE : r_state;
      r_cnt   <= (r_state == ISSUE && !cmd_ready) ? w_cnt_inc : r_state == GAP ? '0 : r_cnt;
      if (w_pop) {r_type, r_data} <= w_head;
      r_ovf   <= w_ovf || (r_ovf && !clr_err);
      r_multi <= w_multi || (r_multi && !clr_err);
      r_tmo   <= w_abort || (r_tmo && !clr_err);
    end
endmodule

// File: tb/tb_nios2_debug_action_sched.sv
// tb_nios2_debug_action_sched: vector table, directed corner sequences and a queue-based random reference check
module tb_nios2_debug_action_sched;
  localparam int D = 4, TO = 8, JW = 38;
  logic clk = 1'b0, reset_n = 1'b0, cmd_ready = 1'b0, clr_err = 1'b0;
  logic [5:0] act_pulse = '0;
  logic [JW-1:0] act_jdo = '0, cmd_data;
  logic [2:0] cmd_type, level;
  logic cmd_valid, busy, overflow_err, multi_err, timeout_err;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  nios2_debug_action_sched #(.FIFO_DEPTH(D), .JDO_W(JW), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .act_pulse(act_pulse), .act_jdo(act_jdo),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .busy(busy), .level(level), .overflow_err(overflow_err), .multi_err(multi_err),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );
  typedef struct {logic [2:0] t; logic [JW-1:0] d;} ent_t;
  ent_t mq[$];
  ent_t m_cur;
  bit m_iss, m_cool, m_ovf, m_mul, m_tmo;
  int m_age;
  typedef struct {
    logic [5:0] p; logic [JW-1:0] j; logic r; logic c;
    logic v; logic [2:0] t; logic [JW-1:0] d; logic [2:0] l; logic b; logic [2:0] e;
  } vec_t;
  vec_t tbl[9];
  logic [JW-1:0] got[$];
  int cnt;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset_n = 1'b0; act_pulse = '0; act_jdo = '0; cmd_ready = 1'b0; clr_err = 1'b0;
    repeat (2) step;
    reset_n = 1'b1;
    mq.delete(); m_iss = 0; m_cool = 0; m_ovf = 0; m_mul = 0; m_tmo = 0; m_age = 0;
  endtask
  task automatic model_edge;
    bit tmo_ev, ovf_ev;
    ent_t e;
    tmo_ev = 0; ovf_ev = 0; e.t = '0;
    if (m_iss) begin
      if (cmd_ready) begin m_iss = 0; m_cool = 1; end
      else begin
        m_age++;
        if (m_age >= TO) begin m_iss = 0; m_cool = 1; tmo_ev = 1; end
      end
    end else if (m_cool) m_cool = 0;
    else if (mq.size() > 0) begin m_cur = mq.pop_front(); m_iss = 1; m_age = 0; end
    if (act_pulse != 0) begin
      for (int i = 0; i < 6; i++) if (act_pulse[i]) begin e.t = 3'(i); break; end
      e.d = act_jdo;
      if (mq.size() < D) mq.push_back(e); else ovf_ev = 1;
    end
    m_ovf = ovf_ev || (m_ovf && !clr_err);
    m_mul = ($countones(act_pulse) > 1) || (m_mul && !clr_err);
    m_tmo = tmo_ev || (m_tmo && !clr_err);
  endtask
  initial begin
    tbl[0] = '{6'h04, 38'h2A_DEAD_BEEF, 1'b1, 1'b0, 1'b0, 3'd0, 38'd0, 3'd1, 1'b1, 3'b000};
    tbl[1] = '{6'h00, 38'd0, 1'b1, 1'b0, 1'b1, 3'd2, 38'h2A_DEAD_BEEF, 3'd0, 1'b1, 3'b000};
    tbl[2] = '{6'h00, 38'd0, 1'b1, 1'b0, 1'b0, 3'd0, 38'd0, 3'd0, 1'b1, 3'b000};
    tbl[3] = '{6'h00, 38'd0, 1'b1, 1'b0, 1'b0, 3'd0, 38'd0, 3'd0, 1'b0, 3'b000};
    tbl[4] = '{6'h22, 38'h15, 1'b1, 1'b0, 1'b0, 3'd0, 38'd0, 3'd1, 1'b1, 3'b010};
    tbl[5] = '{6'h00, 38'd0, 1'b1, 1'b0, 1'b1, 3'd1, 38'h15, 3'd0, 1'b1, 3'b010};
    tbl[6] = '{6'h00, 38'd0, 1'b1, 1'b0, 1'b0, 3'd0, 38'd0, 3'd0, 1'b1, 3'b010};
    tbl[7] = '{6'h00, 38'd0, 1'b1, 1'b0, 1'b0, 3'd0, 38'd0, 3'd0, 1'b0, 3'b010};
    tbl[8] = '{6'h00, 38'd0, 1'b1, 1'b1, 1'b0, 3'd0, 38'd0, 3'd0, 1'b0, 3'b000};
    do_reset;
    chk("reset valid", cmd_valid, 0);
    chk("reset level", level, 0);
    chk("reset busy", busy, 0);
    chk("reset type", cmd_type, 0);
    chk("reset data", cmd_data, 0);
    chk("reset errs", {timeout_err, multi_err, overflow_err}, 0);
    for (int i = 0; i < 9; i++) begin
      act_pulse = tbl[i].p; act_jdo = tbl[i].j; cmd_ready = tbl[i].r; clr_err = tbl[i].c;
      step;
      act_pulse = '0; clr_err = 1'b0;
      chk($sformatf("vec%0d valid", i), cmd_valid, tbl[i].v);
      chk($sformatf("vec%0d level", i), level, tbl[i].l);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].b);
      chk($sformatf("vec%0d errs", i), {timeout_err, multi_err, overflow_err}, tbl[i].e);
      if (tbl[i].v) begin
        chk($sformatf("vec%0d type", i), cmd_type, tbl[i].t);
        chk($sformatf("vec%0d data", i), cmd_data, tbl[i].d);
      end
    end
    do_reset;
    for (int i = 0; i < 6; i++) begin
      act_pulse = 6'(1 << i); act_jdo = 38'(100 + i);
      step;
    end
    act_pulse = '0;
    chk("ovf level", level, 4);
    chk("ovf err", overflow_err, 1);
    chk("ovf valid", cmd_valid, 1);
    chk("ovf head data", cmd_data, 100);
    cmd_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 25; i++) begin
      step;
      if (cmd_valid) got.push_back(cmd_data);
    end
    chk("ovf issued count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk($sformatf("ovf issued %0d", i), got[i], 101 + i);
    do_reset;
    act_pulse = 6'h01; act_jdo = 38'hA1; step;
    act_pulse = 6'h08; act_jdo = 38'hB2; step;
    act_pulse = '0;
    chk("tmo first valid", cmd_valid, 1);
    cnt = 0;
    for (int i = 0; i < 20 && cmd_valid; i++) begin cnt++; step; end
    chk("tmo valid cycles", cnt, TO);
    chk("tmo err", timeout_err, 1);
    chk("tmo valid drop", cmd_valid, 0);
    step;
    chk("tmo gap valid", cmd_valid, 0);
    step;
    chk("tmo next valid", cmd_valid, 1);
    chk("tmo next type", cmd_type, 3);
    chk("tmo next data", cmd_data, 38'hB2);
    clr_err = 1'b1; step; clr_err = 1'b0;
    chk("tmo clr", timeout_err, 0);
    do_reset;
    act_pulse = 6'h20; act_jdo = 38'h3C; step;
    act_pulse = '0; step;
    chk("bnd valid", cmd_valid, 1);
    repeat (TO - 1) step;
    chk("bnd still valid", cmd_valid, 1);
    cmd_ready = 1'b1; step; cmd_ready = 1'b0;
    chk("bnd valid drop", cmd_valid, 0);
    chk("bnd no tmo", timeout_err, 0);
    step; step;
    chk("bnd idle busy", busy, 0);
    chk("bnd tmo later", timeout_err, 0);
    do_reset;
    act_pulse = 6'h01; step;
    act_pulse = 6'h02; step;
    act_pulse = 6'h0C; step;
    act_pulse = 6'h08; step;
    act_pulse = '0;
    chk("rst pre level", level, 3);
    chk("rst pre valid", cmd_valid, 1);
    chk("rst pre multi", multi_err, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst async valid", cmd_valid, 0);
    chk("rst async level", level, 0);
    chk("rst async busy", busy, 0);
    chk("rst async errs", {timeout_err, multi_err, overflow_err}, 0);
    step;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk($sformatf("rst post%0d", i), {cmd_valid, busy, level}, 0);
    end
    do_reset;
    for (int c = 0; c < 1500; c++) begin
      int rp;
      rp = ((c / 250) % 4 == 0) ? 90 : ((c / 250) % 4 == 1) ? 50 : ((c / 250) % 4 == 2) ? 10 : 0;
      act_pulse = ($urandom % 3 == 0) ? 6'($urandom) : 6'd0;
      act_jdo = 38'({$urandom, $urandom});
      cmd_ready = ($urandom % 100) < rp;
      clr_err = ($urandom % 25) == 0;
      model_edge;
      step;
      chk($sformatf("rnd%0d valid", c), cmd_valid, m_iss);
      chk($sformatf("rnd%0d level", c), level, mq.size());
      chk($sformatf("rnd%0d busy", c), busy, mq.size() > 0 || m_iss || m_cool);
      chk($sformatf("rnd%0d errs", c), {timeout_err, multi_err, overflow_err}, {m_tmo, m_mul, m_ovf});
      if (m_iss) chk($sformatf("rnd%0d cmd", c), {cmd_type, cmd_data}, {m_cur.t, m_cur.d});
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
